// File: rtl/ecc_secded_if.sv
// Handshake/data bundle between the link or storage receiver, the SEC-DED
// decoder and the consumer of corrected words.
interface ecc_secded_if #(
  parameter int DATA_W  = 32,
  parameter int CHECK_W = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [CHECK_W-1:0] in_check;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [CHECK_W-1:0] out_syndrome;
  logic               out_err_single;
  logic               out_err_double;

  // Producer/consumer side: drives words in, accepts corrected words.
  modport master (
    output in_valid, in_data, in_check, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome,
           out_err_single, out_err_double
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_data, in_check, out_ready,
    output in_ready, out_valid, out_data, out_syndrome,
           out_err_single, out_err_double
  );
endinterface

// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined SEC-DED decoder for an extended Hamming code.
// Stage 1 captures data plus syndrome s and overall parity p; stage 2 holds
// the corrected word, syndrome and error class. Both stages stall together
// whenever the output holds a word the consumer has not taken.
module ecc_secded_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  ecc_secded_if.slave      bus,
  input  logic             corr_en,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  // Smallest R with 2**R >= DATA_W+R+1.
  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int R       = calc_r(DATA_W);
  localparam int CHECK_W = R + 1;
  localparam int NPOS    = DATA_W + R;
  localparam logic [R-1:0] NPOS_R = R'(NPOS);

  // Codeword position (1-based) of data bit i: the i-th non-power-of-two slot.
  function automatic int dpos(input int i);
    int cnt;
    int p;
    cnt = -1;
    p   = 0;
    for (int q = 1; q <= NPOS; q++) begin
      if ((q & (q - 1)) != 0) begin
        cnt++;
        if (cnt == i) p = q;
      end
    end
    return p;
  endfunction

  logic              adv;
  logic [R-1:0]      s_calc;
  logic [R-1:0]      s_in;
  logic              p_in;

  logic              v1;
  logic [DATA_W-1:0] d1;
  logic [R-1:0]      s1;
  logic              p1;

  logic              beyond;
  logic              sgl;
  logic              dbl;
  logic [DATA_W-1:0] fix_data;

  // Pipeline advances when the output slot is empty or being drained.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Recompute Hamming bits from the received data and form the syndrome.
  always_comb begin
    s_calc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < R; k++) begin
        if (((dpos(i) >> k) & 1) != 0) s_calc[k] = s_calc[k] ^ bus.in_data[i];
      end
    end
    s_in = s_calc ^ bus.in_check[R-1:0];
    p_in = ^{bus.in_data, bus.in_check};
  end

  // Stage 1: capture word, syndrome and parity; a non-accepted slot is a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      s1 <= '0;
      p1 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      d1 <= bus.in_data;
      s1 <= s_in;
      p1 <= p_in;
    end
  end

  // Classify the stage-1 word and flip the addressed data bit when allowed.
  // A syndrome past the last codeword position with odd parity can only come
  // from a multi-bit error, so it is reported as double, never corrected.
  always_comb begin
    beyond   = s1 > NPOS_R;
    sgl      = p1 && !beyond;
    dbl      = (!p1 && (s1 != '0)) || (p1 && beyond);
    fix_data = d1;
    for (int i = 0; i < DATA_W; i++) begin
      if (corr_en && sgl && (s1 == R'(dpos(i)))) fix_data[i] = ~d1[i];
    end
  end

  // Stage 2: output registers; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.out_syndrome   <= '0;
      bus.out_err_single <= 1'b0;
      bus.out_err_double <= 1'b0;
    end else if (adv) begin
      bus.out_valid      <= v1;
      bus.out_data       <= fix_data;
      bus.out_syndrome   <= CHECK_W'({p1, s1});
      bus.out_err_single <= v1 && sgl;
      bus.out_err_double <= v1 && dbl;
    end
  end

  // Saturating single-error counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_single <= '0;
    end else if (clr_cnt) begin
      cnt_single <= '0;
    end else if (adv && v1 && sgl && (cnt_single != '1)) begin
      cnt_single <= cnt_single + 1'b1;
    end
  end

  // Saturating double-error counter; same clear priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_double <= '0;
    end else if (clr_cnt) begin
      cnt_double <= '0;
    end else if (adv && v1 && dbl && (cnt_double != '1)) begin
      cnt_double <= cnt_double + 1'b1;
    end
  end

endmodule
